i2c_codec_writer: RTL
=====================

# i2c_codec_writer

Single-master, write-only I2C transmitter that delivers 16-bit control words to the WM8731 codec at fixed device address 0x34 (7'h1A + W). It sits directly downstream of the codec configuration controller: the controller presents a word on DATA with ENABLE high and advances on each rising edge of FINISHED. It drives the board pins AUD_SCLK (SCL) and AUD_SDAT (SDA).

## Interface

- DIV, 125: MCLK cycles per quarter SCL period (50 MHz / (4·125) = 100 kHz SCL).
- DEV_ADDR, 7'h1A: 7-bit codec address; the R/W bit is always 0.
- GAP_Q, 4: quarter periods FINISHED is held high and the bus stays idle between frames.

- MCLK  in  1  system clock, 50 MHz.
- RESET  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  level request; a new frame starts from IDLE while high.
- DATA  in  16  {reg addr[6:0], reg data[8:0]}; sent MSB first as two bytes.
- FINISHED  out  1  high for GAP_Q quarters after each frame's STOP.
- ACK_ERR  out  1  sticky; set on any NACK, cleared only by reset.
- BUSY  out  1  high from START through STOP.
- SCL  out  1  push-pull I2C clock; no clock stretching is supported.
- SDA  inout  1  open-drain; driven 0 or high-Z only, never 1.

## Operation

- Reset values: SCL=1, SDA=Z, FINISHED=0, ACK_ERR=0, BUSY=0, state=IDLE, all counters 0.
- A quarter tick (qt) fires once every DIV MCLK cycles. All state changes occur on qt only. The divider is free-running while BUSY and restarts at 0 when leaving IDLE.
- States:
  - IDLE: if ENABLE=1, latch DATA into the shift register and go to START. The next word is {DATA[15:8], DATA[7:0]}.
  - START: q0 SDA=Z, SCL=1; q1 SDA=0; q2 SCL=0; q3 go to BIT.
  - BIT: 4 quarters per bit. q0 set SDA from the current MSB (0→0, 1→Z) with SCL=0; q1 SCL=1; q2 hold SCL=1; q3 SCL=0 and shift. After bit 7, go to ACK.
  - ACK: SDA=Z. SCL follows the same 4-quarter pattern. Sample SDA at q2: 0=ACK, 1=NACK. On NACK, set ACK_ERR and go to STOP. On ACK, go to BIT for the next byte if byte_cnt<2, otherwise go to STOP.
  - STOP: q0 SDA=0, SCL=0; q1 SCL=1; q2 SDA=Z; q3 go to HOLD.
  - HOLD: FINISHED=1 for GAP_Q quarters, then FINISHED=0 and go to IDLE.
- Byte order: byte 0 = {DEV_ADDR,0}, byte 1 = DATA[15:8], byte 2 = DATA[7:0]. byte_cnt runs 0..2, bit_cnt runs 7..0.
- DATA and ENABLE changes while BUSY are ignored; the word is latched once, in IDLE.
- If ENABLE is still high when HOLD ends, the next frame starts at the next qt. Each frame therefore produces exactly one FINISHED rising edge.
- If ENABLE drops during a frame, the frame still completes and FINISHED still pulses.
- A NACK aborts the remaining bytes but still produces a STOP and a FINISHED pulse.
- Reset asserted mid-frame: outputs return to reset values immediately, i.e. SCL=1 and SDA=Z asynchronously. The bus may see an incomplete frame; the codec recovers at the next START.
- SDA is sampled through a 2-flop synchronizer. The ACK sample at q2 uses the synchronized value.

## Timing

- SCL period = 4·DIV MCLK cycles (500 at default); duty 50%.
- SDA changes only while SCL=0, except during START and STOP.
- Frame length: START 4 q + 27 bits × 4 q + STOP 4 q = 116 q.
- ENABLE→START latency: ≤ DIV+1 MCLK cycles.
- FINISHED rises DIV MCLK after STOP completes (entry to HOLD) and is high for GAP_Q·DIV cycles.
- Registered outputs: SCL, the SDA output enable, FINISHED, BUSY and ACK_ERR all come from flops, so they are glitch-free. This matters because the upstream controller is clocked on the FINISHED edge.

## Structure

- Shared package codec_pkg: WM8731_ADDR = 7'h1A; the state enum (IDLE, START, BIT, ACK, STOP, HOLD); the default DIV for a 50 MHz MCLK.
- Sub-module i2c_qtick: parameterised divider with sync clear, producing the one-cycle qt strobe.
- Top level contains the FSM, shift register, bit and byte counters, SDA synchronizer and tristate buffer.

## Test plan

- DATA=16'h1E00, ENABLE pulse, slave model ACKs all bytes: bus shows 0x34, 0x1E, 0x00 with 3 ACKs and a STOP. FINISHED rises once. ACK_ERR=0.
- DATA=16'h0E51, slave NACKs the address byte: STOP follows the 9th SCL, bytes 1 and 2 are not sent, ACK_ERR=1 and stays 1 through the next good frame.
- ENABLE held high, DATA changed to 16'h1201 during frame 1: two back-to-back frames; frame 1 is unchanged, frame 2 carries 0x12, 0x01. The gap is GAP_Q quarters (500 MCLK).
- Default DIV: measure SCL high = 250 and period = 500 MCLK cycles. Check that SDA never transitions while SCL=1 except at START and STOP.
- RESET low at bit 3 of byte 1: within the same cycle SCL=1 and SDA=Z, with FINISHED, BUSY and ACK_ERR all 0. After release with ENABLE=1, a fresh full frame is sent.
- ENABLE=0 after reset for 10,000 cycles: SCL=1, SDA=Z and BUSY=0 throughout.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared definitions for the WM8731 control-port writer: codec address,
// frame state encoding and the default divider for a 50 MHz MCLK.
package codec_pkg;

    localparam logic [6:0] WM8731_ADDR   = 7'h1A;
    localparam int         DEFAULT_DIV   = 125;
    localparam int         DEFAULT_GAP_Q = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        HOLD
    } state_t;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period strobe generator: qt is high for one clk every DIV cycles.
// clr holds the count at 0 so the first strobe after release is a full DIV away.
module i2c_qtick #(
    parameter int DIV = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic qt
);
    localparam int W = $clog2(DIV + 1);

    logic [W-1:0] cnt_reg;
    logic         qt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            qt_reg  <= 1'b0;
        end else if (clr) begin
            cnt_reg <= '0;
            qt_reg  <= 1'b0;
        end else if (cnt_reg == W'(DIV - 1)) begin
            cnt_reg <= '0;
            qt_reg  <= 1'b1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            qt_reg  <= 1'b0;
        end
    end

    assign qt = qt_reg;

endmodule

// File: rtl/i2c_codec_writer.sv
// Write-only I2C master delivering {reg addr, reg data} words to a WM8731.
// Frame: START, {addr,W}, DATA[15:8], DATA[7:0], STOP, then a FINISHED pulse.
module i2c_codec_writer
    import codec_pkg::*;
#(
    parameter int         DIV      = DEFAULT_DIV,
    parameter logic [6:0] DEV_ADDR = WM8731_ADDR,
    parameter int         GAP_Q    = DEFAULT_GAP_Q
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [15:0] DATA,
    output logic        FINISHED,
    output logic        ACK_ERR,
    output logic        BUSY,
    output logic        SCL,
    inout  wire         SDA
);
    localparam int GW = $clog2(GAP_Q + 1);

    state_t        state_reg, state_next;
    logic [1:0]    q_reg, q_next;
    logic [2:0]    bit_reg, bit_next;
    logic [1:0]    byte_reg, byte_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic [23:0]   shift_reg, shift_next;
    logic          scl_reg, scl_next;
    logic          sda_oe_reg, sda_oe_next;
    logic          finished_reg, finished_next;
    logic          busy_reg, busy_next;
    logic          ack_err_reg, ack_err_next;
    logic          nack_reg, nack_next;
    logic          sda_meta_reg, sda_sync_reg;
    logic          qt;
    logic          div_clr;

    // Divider parks at 0 while idle with no request, so a request sees a full quarter before START.
    assign div_clr = (state_reg == IDLE) && !ENABLE;

    i2c_qtick #(.DIV(DIV)) u_qtick (
        .clk   (MCLK),
        .rst_n (RESET),
        .clr   (div_clr),
        .qt    (qt)
    );

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            sda_meta_reg <= 1'b1;
            sda_sync_reg <= 1'b1;
        end else begin
            sda_meta_reg <= SDA;
            sda_sync_reg <= sda_meta_reg;
        end
    end

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= IDLE;
            q_reg        <= '0;
            bit_reg      <= '0;
            byte_reg     <= '0;
            gap_reg      <= '0;
            shift_reg    <= '0;
            scl_reg      <= 1'b1;
            sda_oe_reg   <= 1'b0;
            finished_reg <= 1'b0;
            busy_reg     <= 1'b0;
            ack_err_reg  <= 1'b0;
            nack_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            q_reg        <= q_next;
            bit_reg      <= bit_next;
            byte_reg     <= byte_next;
            gap_reg      <= gap_next;
            shift_reg    <= shift_next;
            scl_reg      <= scl_next;
            sda_oe_reg   <= sda_oe_next;
            finished_reg <= finished_next;
            busy_reg     <= busy_next;
            ack_err_reg  <= ack_err_next;
            nack_reg     <= nack_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        q_next        = q_reg;
        bit_next      = bit_reg;
        byte_next     = byte_reg;
        gap_next      = gap_reg;
        shift_next    = shift_reg;
        scl_next      = scl_reg;
        sda_oe_next   = sda_oe_reg;
        finished_next = finished_reg;
        busy_next     = busy_reg;
        ack_err_next  = ack_err_reg;
        nack_next     = nack_reg;

        if (qt) begin
            q_next = q_reg + 2'd1;
            case (state_reg)
                IDLE: begin
                    q_next = 2'd0;
                    if (ENABLE) begin
                        shift_next = {DEV_ADDR, 1'b0, DATA};
                        bit_next   = 3'd7;
                        byte_next  = 2'd0;
                        busy_next  = 1'b1;
                        state_next = START;
                    end
                end
                START: begin
                    case (q_reg)
                        2'd0: begin
                            sda_oe_next = 1'b0;
                            scl_next    = 1'b1;
                        end
                        2'd1:    sda_oe_next = 1'b1;
                        2'd2:    scl_next    = 1'b0;
                        default: state_next  = BIT;
                    endcase
                end
                BIT: begin
                    case (q_reg)
                        2'd0: begin
                            sda_oe_next = ~shift_reg[23];
                            scl_next    = 1'b0;
                        end
                        2'd1: scl_next = 1'b1;
                        2'd2: scl_next = 1'b1;
                        default: begin
                            scl_next   = 1'b0;
                            shift_next = {shift_reg[22:0], 1'b0};
                            if (bit_reg == 3'd0) begin
                                bit_next   = 3'd7;
                                state_next = ACK;
                            end else begin
                                bit_next = bit_reg - 3'd1;
                            end
                        end
                    endcase
                end
                ACK: begin
                    case (q_reg)
                        2'd0: begin
                            sda_oe_next = 1'b0;
                            scl_next    = 1'b0;
                        end
                        2'd1: scl_next  = 1'b1;
                        2'd2: nack_next = sda_sync_reg;
                        default: begin
                            scl_next = 1'b0;
                            if (nack_reg) begin
                                ack_err_next = 1'b1;
                                state_next   = STOP;
                            end else if (byte_reg < 2'd2) begin
                                byte_next  = byte_reg + 2'd1;
                                state_next = BIT;
                            end else begin
                                state_next = STOP;
                            end
                        end
                    endcase
                end
                STOP: begin
                    case (q_reg)
                        2'd0: begin
                            sda_oe_next = 1'b1;
                            scl_next    = 1'b0;
                        end
                        2'd1: scl_next    = 1'b1;
                        2'd2: sda_oe_next = 1'b0;
                        default: begin
                            busy_next  = 1'b0;
                            gap_next   = '0;
                            state_next = HOLD;
                        end
                    endcase
                end
                HOLD: begin
                    if (gap_reg == GW'(GAP_Q)) begin
                        finished_next = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        finished_next = 1'b1;
                        gap_next      = gap_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign SCL      = scl_reg;
    assign SDA      = sda_oe_reg ? 1'b0 : 1'bz;
    assign FINISHED = finished_reg;
    assign BUSY     = busy_reg;
    assign ACK_ERR  = ack_err_reg;

endmodule
